// File: rtl/freq_calc_bcd_if.sv
// freq_calc_bcd_if: operand/result bundle between the gate counter and the frequency back end
//   master (measurement top / bench): drives start, m_in, n_in; observes results
//   slave  (freq_calc_bcd):           samples operands; drives busy, valid, freq_bin, bcd, ovf, div0
//   start     1-clk strobe, m_in/n_in valid
//   m_in      signal-cycle count of the gate (MW bits)
//   n_in      reference-cycle count of the gate (NW bits)
//   busy      high from capture until the valid pulse inclusive
//   valid     1-clk pulse, result outputs updated
//   freq_bin  saturated frequency in Hz (BW bits)
//   bcd       packed BCD of freq_bin, [3:0] = units digit
//   ovf       quotient exceeded 10^DIGITS-1 (includes divide by zero)
//   div0      n_in was 0 at capture
interface freq_calc_bcd_if #(
   parameter int MW     = 31,
   parameter int NW     = 27,
   parameter int DIGITS = 8
);
   localparam int BW = 27;
   logic                  start;
   logic [MW-1:0]         m_in;
   logic [NW-1:0]         n_in;
   logic                  busy;
   logic                  valid;
   logic [BW-1:0]         freq_bin;
   logic [4*DIGITS-1:0]   bcd;
   logic                  ovf;
   logic                  div0;
   modport master (
      output start, m_in, n_in,
      input  busy, valid, freq_bin, bcd, ovf, div0
   );
   modport slave (
      input  start, m_in, n_in,
      output busy, valid, freq_bin, bcd, ovf, div0
   );
endinterface

// File: rtl/freq_calc_bcd.sv
// freq_calc_bcd: F = FREF*M/N via restoring divider, saturation to DIGITS digits, double-dabble BCD
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   freq_calc_bcd_if.slave: start/m_in/n_in in; busy/valid/freq_bin/bcd/ovf/div0 out
//   Optional macro ROUND_EN: adds n_in>>1 to the dividend so the quotient rounds half-up
//   instead of truncating; timing is unchanged.
//   Sequence per measurement: IDLE -> DIV (PW clk) -> SAT (1 clk) -> BCD (BW clk) -> DONE,
//   giving a fixed start->valid latency of PW+BW+2 clocks.
module freq_calc_bcd #(
   parameter int FREF   = 50_000_000,
   parameter int MW     = 31,
   parameter int NW     = 27,
   parameter int PW     = 57,
   parameter int DIGITS = 8
) (
   input logic           clk,
   input logic           rst,
   freq_calc_bcd_if.slave bus
);
   localparam int BW = 27;
   localparam int CW = $clog2(PW);
   localparam int DW = 4 * DIGITS;
   localparam logic [PW-1:0] SAT   = PW'(10**DIGITS - 1);
   localparam logic [BW-1:0] SAT_B = BW'(10**DIGITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_DIV, S_SAT, S_BCD, S_DONE} state_t;

   state_t          state, state_nx;
   logic [PW-1:0]   dvd;
   logic [NW-1:0]   dvs;
   logic [NW:0]     rem;
   logic [CW-1:0]   cnt;
   logic            div0_i, ovf_i;
   logic [BW-1:0]   qs, bin_sh;
   logic [DW-1:0]   bcd_sh, adj;
   logic [PW-1:0]   prod;
   logic [NW+1:0]   rem_sh, diff;
   logic            ge, take, sat;

   // Inputs are only honoured in IDLE and only once busy has dropped, so a start
   // arriving in the cycle of the valid pulse (or the DONE cycle) is discarded.
   assign take = (state == S_IDLE) && bus.start && !bus.busy;

`ifdef ROUND_EN
   assign prod = PW'(bus.m_in) * PW'(FREF) + PW'(bus.n_in >> 1);
`else
   assign prod = PW'(bus.m_in) * PW'(FREF);
`endif

   // One restoring step: the borrow of the trial subtraction is the quotient bit.
   // Because rem < dvs always holds, rem_sh < 2*dvs and the borrow is exact.
   always_comb begin
      rem_sh = {rem, dvd[PW-1]};
      diff   = rem_sh - {2'b00, dvs};
      ge     = ~diff[NW+1];
   end

   assign sat = div0_i || (dvd > SAT);

   // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
   always_comb begin
      adj = bcd_sh;
      for (int i = 0; i < DIGITS; i++)
         if (bcd_sh[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_sh[4*i +: 4] + 4'd3;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= S_IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: state_nx = take ? S_DIV : S_IDLE;
         S_DIV:  state_nx = (cnt == '0) ? S_SAT : S_DIV;
         S_SAT:  state_nx = S_BCD;
         S_BCD:  state_nx = (cnt == '0) ? S_DONE : S_BCD;
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         dvd          <= '0;
         dvs          <= '0;
         rem          <= '0;
         cnt          <= '0;
         div0_i       <= 1'b0;
         ovf_i        <= 1'b0;
         qs           <= '0;
         bin_sh       <= '0;
         bcd_sh       <= '0;
         bus.busy     <= 1'b0;
         bus.valid    <= 1'b0;
         bus.freq_bin <= '0;
         bus.bcd      <= '0;
         bus.ovf      <= 1'b0;
         bus.div0     <= 1'b0;
      end else begin
         // busy stays up through DONE so it covers the valid cycle, then falls in IDLE.
         bus.busy  <= take || (state != S_IDLE);
         bus.valid <= (state == S_DONE);
         case (state)
            S_IDLE:
               if (take) begin
                  dvd    <= prod;
                  dvs    <= bus.n_in;
                  rem    <= '0;
                  cnt    <= CW'(PW - 1);
                  div0_i <= (bus.n_in == '0);
               end
            S_DIV: begin
               // Quotient bits enter at the LSB as dividend bits leave the MSB,
               // so dvd holds the full quotient after PW steps.
               rem <= ge ? diff[NW:0] : rem_sh[NW:0];
               dvd <= {dvd[PW-2:0], ge};
               cnt <= cnt - 1'b1;
            end
            S_SAT: begin
               ovf_i  <= sat;
               qs     <= sat ? SAT_B : dvd[BW-1:0];
               bin_sh <= sat ? SAT_B : dvd[BW-1:0];
               bcd_sh <= '0;
               cnt    <= CW'(BW - 1);
            end
            S_BCD: begin
               bcd_sh <= {adj[DW-2:0], bin_sh[BW-1]};
               bin_sh <= {bin_sh[BW-2:0], 1'b0};
               cnt    <= cnt - 1'b1;
            end
            S_DONE: begin
               bus.freq_bin <= qs;
               bus.bcd      <= bcd_sh;
               bus.ovf      <= ovf_i;
               bus.div0     <= div0_i;
            end
            default: ;
         endcase
      end
endmodule
